// File: rtl/ct_op_sequencer.sv
// Micro-sequencer for q-basis ciphertext ops: single-cycle adds and the two-half
// TWIST/NTT/MUL/INTT/UNTWIST walk for ciphertext-plaintext multiply.
module ct_op_sequencer #(
  parameter int unsigned REG_NPOLY   = 32,
  parameter int unsigned NTT_TIMEOUT = 1023,
  localparam int unsigned IW         = $clog2(REG_NPOLY)
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          op_valid_i,
  output logic          op_ready_o,
  input  logic [1:0]    op_mode_i,
  input  logic [IW-1:0] op_src0_i,
  input  logic [IW-1:0] op_src1_i,
  input  logic [IW-1:0] op_src2_i,
  input  logic [IW-1:0] op_src3_i,
  input  logic [IW-1:0] op_dst0_i,
  input  logic [IW-1:0] op_dst1_i,
  input  logic          ntt_done_i,
  output logic [2:0]    ctl_step_o,
  output logic          ctl_half_o,
  output logic [IW-1:0] ctl_src_a_o,
  output logic [IW-1:0] ctl_src_b_o,
  output logic          ntt_start_o,
  output logic          ntt_inverse_o,
  output logic          wb0_en_o,
  output logic          wb1_en_o,
  output logic          done_o,
  output logic          busy_o,
  output logic [1:0]    err_o
);

  localparam int unsigned CntW = $clog2(NTT_TIMEOUT + 1);

  typedef enum logic [3:0] {
    StIdle, StAdd, StTwist, StNttS, StNttW, StMul, StInttS, StInttW, StUntwist, StFin
  } state_e;

  state_e          state_q, state_d;
  logic [IW-1:0]   src0_q, src0_d, src1_q, src1_d, src2_q, src2_d;
  logic            half_q, half_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [1:0]      err_q, err_d;
  logic            mul_seq;

  // Destinations are resolved by the regfile from the write-enable alone; CT1.B is not
  // an operand of any supported op.
  logic unused_inputs;
  assign unused_inputs = ^{op_src3_i, op_dst0_i, op_dst1_i};

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
      src0_q  <= '0;
      src1_q  <= '0;
      src2_q  <= '0;
      half_q  <= 1'b0;
      cnt_q   <= '0;
      err_q   <= '0;
    end else begin
      state_q <= state_d;
      src0_q  <= src0_d;
      src1_q  <= src1_d;
      src2_q  <= src2_d;
      half_q  <= half_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    src0_d  = src0_q;
    src1_d  = src1_q;
    src2_d  = src2_q;
    half_d  = half_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    unique case (state_q)
      StIdle: begin
        if (op_valid_i) begin
          src0_d = op_src0_i;
          src1_d = op_src1_i;
          src2_d = op_src2_i;
          half_d = 1'b0;
          err_d  = '0;
          unique case (op_mode_i)
            2'b00, 2'b01: state_d = StAdd;
            2'b10:        state_d = StTwist;
            default: begin
              err_d[0] = 1'b1;
              state_d  = StFin;
            end
          endcase
        end
      end
      StAdd:   state_d = StFin;
      StTwist: state_d = StNttS;
      StNttS: begin
        cnt_d   = '0;
        state_d = StNttW;
      end
      StMul:   state_d = StInttS;
      StInttS: begin
        cnt_d   = '0;
        state_d = StInttW;
      end
      StNttW, StInttW: begin
        // ntt_done wins over a coincident timeout.
        if (ntt_done_i) begin
          state_d = (state_q == StNttW) ? StMul : StUntwist;
        end else if (cnt_q == CntW'(NTT_TIMEOUT - 1)) begin
          err_d[1] = 1'b1;
          state_d  = StFin;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StUntwist: begin
        if (half_q) begin
          state_d = StFin;
        end else begin
          half_d  = 1'b1;
          state_d = StTwist;
        end
      end
      StFin: begin
        half_d  = 1'b0;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    op_ready_o    = (state_q == StIdle);
    busy_o        = (state_q != StIdle);
    done_o        = (state_q == StFin);
    err_o         = err_q;
    ctl_step_o    = 3'd0;
    ctl_half_o    = 1'b0;
    ctl_src_a_o   = '0;
    ctl_src_b_o   = '0;
    ntt_start_o   = 1'b0;
    ntt_inverse_o = 1'b0;
    wb0_en_o      = 1'b0;
    wb1_en_o      = 1'b0;
    mul_seq       = 1'b1;
    unique case (state_q)
      StAdd: begin
        mul_seq     = 1'b0;
        ctl_step_o  = 3'd1;
        ctl_src_a_o = src0_q;
        ctl_src_b_o = src2_q;
        wb0_en_o    = 1'b1;
        wb1_en_o    = 1'b1;
      end
      StTwist: ctl_step_o = 3'd2;
      StNttS: begin
        ctl_step_o  = 3'd3;
        ntt_start_o = 1'b1;
      end
      StNttW: ctl_step_o = 3'd0;
      StMul:  ctl_step_o = 3'd4;
      StInttS: begin
        ctl_step_o    = 3'd5;
        ntt_start_o   = 1'b1;
        ntt_inverse_o = 1'b1;
      end
      StInttW: ntt_inverse_o = 1'b1;
      StUntwist: begin
        ctl_step_o = 3'd6;
        wb0_en_o   = ~half_q;
        wb1_en_o   = half_q;
      end
      default: mul_seq = 1'b0;
    endcase
    if (mul_seq) begin
      ctl_half_o  = half_q;
      ctl_src_a_o = half_q ? src1_q : src0_q;
      ctl_src_b_o = src2_q;
    end
  end

endmodule

// File: tb/tb_ct_op_sequencer.sv
// Directed bench for ct_op_sequencer: adds, full multiply walk, timeout, illegal op,
// mid-sequence reset and ignored stray inputs.
module tb_ct_op_sequencer;

  localparam int unsigned IW = 5;

  logic          clk_i = 1'b0;
  logic          rst_ni;
  logic          op_valid_i;
  logic          op_ready_o;
  logic [1:0]    op_mode_i;
  logic [IW-1:0] op_src0_i, op_src1_i, op_src2_i, op_src3_i, op_dst0_i, op_dst1_i;
  logic          ntt_done_i;
  logic [2:0]    ctl_step_o;
  logic          ctl_half_o;
  logic [IW-1:0] ctl_src_a_o, ctl_src_b_o;
  logic          ntt_start_o, ntt_inverse_o, wb0_en_o, wb1_en_o, done_o, busy_o;
  logic [1:0]    err_o;

  int vecs = 0;
  int miscmp = 0;

  ct_op_sequencer #(
    .REG_NPOLY  (32),
    .NTT_TIMEOUT(8)
  ) dut (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .op_valid_i   (op_valid_i),
    .op_ready_o   (op_ready_o),
    .op_mode_i    (op_mode_i),
    .op_src0_i    (op_src0_i),
    .op_src1_i    (op_src1_i),
    .op_src2_i    (op_src2_i),
    .op_src3_i    (op_src3_i),
    .op_dst0_i    (op_dst0_i),
    .op_dst1_i    (op_dst1_i),
    .ntt_done_i   (ntt_done_i),
    .ctl_step_o   (ctl_step_o),
    .ctl_half_o   (ctl_half_o),
    .ctl_src_a_o  (ctl_src_a_o),
    .ctl_src_b_o  (ctl_src_b_o),
    .ntt_start_o  (ntt_start_o),
    .ntt_inverse_o(ntt_inverse_o),
    .wb0_en_o     (wb0_en_o),
    .wb1_en_o     (wb1_en_o),
    .done_o       (done_o),
    .busy_o       (busy_o),
    .err_o        (err_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    vecs++;
    assert (obs === exp_v)
    else begin
      miscmp++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  task automatic offer(input logic [1:0] mode, input logic [IW-1:0] s0, input logic [IW-1:0] s1,
                       input logic [IW-1:0] s2);
    op_valid_i = 1'b1;
    op_mode_i  = mode;
    op_src0_i  = s0;
    op_src1_i  = s1;
    op_src2_i  = s2;
    op_src3_i  = 5'd4;
    op_dst0_i  = 5'd1;
    op_dst1_i  = 5'd2;
  endtask

  // Expected per-cycle behaviour of a multiply with ntt_done one cycle after each start;
  // bit/index c is cycle c after the accepting edge.
  int          exp_step [16] = '{0, 2, 3, 0, 4, 5, 0, 6, 2, 3, 0, 4, 5, 0, 6, 0};
  logic [15:0] exp_start = 16'h1224;
  logic [15:0] exp_inv   = 16'h3060;
  logic [15:0] exp_wb0   = 16'h0080;
  logic [15:0] exp_wb1   = 16'h4000;
  logic [15:0] exp_done  = 16'h8000;
  logic [15:0] exp_half  = 16'h7F00;
  logic [15:0] drv_done  = 16'h2458;  // real returns at 3,6,10,13 plus a stray one in MUL (4)

  initial begin
    int dones;
    rst_ni     = 1'b0;
    op_valid_i = 1'b0;
    op_mode_i  = 2'b00;
    op_src0_i  = '0;
    op_src1_i  = '0;
    op_src2_i  = '0;
    op_src3_i  = '0;
    op_dst0_i  = '0;
    op_dst1_i  = '0;
    ntt_done_i = 1'b0;
    #2;
    check("rst_ready", op_ready_o, 1);
    check("rst_busy", busy_o, 0);
    check("rst_step", ctl_step_o, 0);
    check("rst_wb", {wb0_en_o, wb1_en_o, done_o, ntt_start_o}, 0);
    check("rst_err", err_o, 0);
    tick();
    tick();
    rst_ni = 1'b1;
    tick();

    // CT_CT_ADD
    offer(2'b00, 5'd3, 5'd9, 5'd7);
    tick();
    op_valid_i = 1'b0;
    check("add_step", ctl_step_o, 1);
    check("add_wb", {wb0_en_o, wb1_en_o}, 2'b11);
    check("add_src_a", ctl_src_a_o, 3);
    check("add_src_b", ctl_src_b_o, 7);
    check("add_ready", op_ready_o, 0);
    check("add_done_early", done_o, 0);
    tick();
    check("add_done", done_o, 1);
    check("add_fin_wb", {wb0_en_o, wb1_en_o}, 0);
    tick();
    check("add_idle_ready", op_ready_o, 1);
    check("add_idle_done", done_o, 0);

    // CT_PT_ADD uses the same operands
    offer(2'b01, 5'd12, 5'd9, 5'd20);
    tick();
    op_valid_i = 1'b0;
    check("ptadd_src", {ctl_step_o, ctl_src_a_o, ctl_src_b_o}, {3'd1, 5'd12, 5'd20});
    tick();
    tick();

    // CT_PT_MUL, op_valid held high and inputs changed while busy
    offer(2'b10, 5'd5, 5'd6, 5'd10);
    tick();
    op_src0_i = 5'd31;
    op_src1_i = 5'd30;
    for (int c = 1; c <= 15; c++) begin
      check($sformatf("mul_step_c%0d", c), ctl_step_o, exp_step[c]);
      check($sformatf("mul_start_c%0d", c), ntt_start_o, exp_start[c]);
      check($sformatf("mul_wb_c%0d", c), {wb0_en_o, wb1_en_o}, {exp_wb0[c], exp_wb1[c]});
      check($sformatf("mul_done_c%0d", c), done_o, exp_done[c]);
      check($sformatf("mul_half_c%0d", c), ctl_half_o, exp_half[c]);
      check($sformatf("mul_src_a_c%0d", c), ctl_src_a_o, (c == 15) ? 0 : (c >= 8 ? 6 : 5));
      check($sformatf("mul_ready_c%0d", c), op_ready_o, 0);
      if (exp_start[c] || exp_inv[c])
        check($sformatf("mul_inv_c%0d", c), ntt_inverse_o, exp_inv[c]);
      if (c == 15) op_valid_i = 1'b0;
      ntt_done_i = drv_done[c];
      tick();
    end
    // cycle 16: IDLE, stray ntt_done must not start anything
    check("mul_idle_ready", op_ready_o, 1);
    ntt_done_i = 1'b1;
    tick();
    ntt_done_i = 1'b0;
    check("stray_done_busy", busy_o, 0);
    check("stray_done_step", ctl_step_o, 0);

    // Timeout: ntt_done never returned
    offer(2'b10, 5'd1, 5'd2, 5'd3);
    tick();
    op_valid_i = 1'b0;
    dones = 0;
    for (int c = 1; c <= 13; c++) begin
      check($sformatf("to_wb_c%0d", c), {wb0_en_o, wb1_en_o}, 0);
      if (c == 10) check("to_err_pre", err_o, 0);
      if (c == 11) begin
        check("to_done", done_o, 1);
        check("to_err", err_o, 2'b10);
      end
      dones += int'(done_o);
      tick();
    end
    check("to_done_count", dones, 1);
    check("to_err_sticky", err_o, 2'b10);
    check("to_ready", op_ready_o, 1);

    // Reset while waiting for the forward NTT
    offer(2'b10, 5'd1, 5'd2, 5'd3);
    tick();
    op_valid_i = 1'b0;
    tick();
    tick();
    check("rmid_in_wait", busy_o, 1);
    rst_ni = 1'b0;
    tick();
    rst_ni = 1'b1;
    check("rmid_busy", busy_o, 0);
    check("rmid_ready", op_ready_o, 1);
    check("rmid_err", err_o, 0);
    check("rmid_wb", {wb0_en_o, wb1_en_o, done_o}, 0);
    tick();
    check("rmid_stays_idle", busy_o, 0);

    // Illegal mode, then an add clears err
    offer(2'b11, 5'd1, 5'd2, 5'd3);
    tick();
    op_valid_i = 1'b0;
    check("ill_done", done_o, 1);
    check("ill_err", err_o, 2'b01);
    check("ill_wb", {wb0_en_o, wb1_en_o, ctl_step_o}, 0);
    tick();
    check("ill_ready", op_ready_o, 1);
    check("ill_err_sticky", err_o, 2'b01);
    offer(2'b00, 5'd3, 5'd9, 5'd7);
    tick();
    op_valid_i = 1'b0;
    check("ill_clear_err", err_o, 0);
    check("ill_clear_step", ctl_step_o, 1);
    tick();
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vecs, miscmp);
    $finish;
  end

endmodule

// File: doc/ct_op_sequencer.md
Name: ct_op_sequencer

Overview:
- Micro-sequencer between the instruction source and the q-basis ciphertext datapath (adders, multipliers, NTT units, regfile write ports).
- Accepts one ciphertext operation at a time over a valid/ready handshake.
- Single-step ops (CT-CT add, CT-PT add) complete in one cycle.
- CT-PT multiply is walked through TWIST -> NTT -> MUL -> INTT -> UNTWIST, first for the A half and then for the B half. The NTT unit is multi-cycle and handshaked, and the whole multiply sequence is guarded by a timeout.

Parameters:
- REG_NPOLY, 32, number of polynomial registers; index width IW = $clog2(REG_NPOLY).
- NTT_TIMEOUT, 1023, maximum cycles to wait for ntt_done before aborting.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- op_valid  in  1  operation offered.
- op_ready  out  1  sequencer can accept (high only in IDLE).
- op_mode  in  2  00 CT_CT_ADD, 01 CT_PT_ADD, 10 CT_PT_MUL, 11 illegal.
- op_src0/op_src1/op_src2/op_src3  in  IW each  source register indices (CT0.A, CT0.B, CT1.A/PT, CT1.B).
- op_dst0/op_dst1  in  IW each  destination indices.
- ntt_done  in  1  NTT unit finished current transform (1-cycle pulse).
- ctl_step  out  3  0 NONE, 1 ADD, 2 TWIST, 3 NTT, 4 MUL, 5 INTT, 6 UNTWIST.
- ctl_half  out  1  0 = A half, 1 = B half.
- ctl_src_a/ctl_src_b  out  IW each  operand indices driven to regfile.
- ntt_start  out  1  1-cycle start pulse to NTT unit.
- ntt_inverse  out  1  direction; valid while ntt_start high and held until ntt_done.
- wb0_en/wb1_en  out  1 each  regfile write enables for op_dst0/op_dst1.
- done  out  1  1-cycle completion pulse.
- busy  out  1  high when not IDLE.
- err  out  2  sticky: bit0 illegal op, bit1 NTT timeout; cleared by the next accepted op.

Behaviour:
- Reset (reset=0, asynchronous): state IDLE; every output 0 except op_ready=1; latched indices, counters and err cleared. Assertion mid-sequence aborts immediately with no write-back.
- Accept on op_valid & op_ready (rising edge). All op_* fields are latched; inputs are ignored until the next IDLE.
- States: IDLE, ADD, TWIST, NTT_S, NTT_W, MUL, INTT_S, INTT_W, UNTWIST, FIN.
- CT_CT_ADD or CT_PT_ADD → ADD for exactly one cycle:
  - ctl_step=1, wb0_en=wb1_en=1.
  - CT_CT_ADD: ctl_src_a=src0, ctl_src_b=src2.
  - CT_PT_ADD: ctl_src_a=src0, ctl_src_b=src2.
  - Then FIN.
- Illegal mode: err[0] set in the cycle after accept, no write enables, FIN.
- CT_PT_MUL, half 0:
  - TWIST (1 cycle, src_a=src0, src_b=src2).
  - NTT_S (ntt_start=1, inverse=0) → NTT_W until ntt_done.
  - MUL (1 cycle).
  - INTT_S (ntt_start=1, inverse=1) → INTT_W until ntt_done.
  - UNTWIST (1 cycle, wb0_en=1).
- CT_PT_MUL, half 1: same sequence with src_a=src1, ends with wb1_en=1, then FIN.
- Minimum latency with ntt_done returned 1 cycle after start: 2×(1+1+1+1+1+1+1)=14 cycles, plus FIN.
- Timeout: a wait counter resets on entry to NTT_W/INTT_W. When it reaches NTT_TIMEOUT without ntt_done:
  - err[1] set; remaining steps, including the B half, skipped; no further wb.
  - → FIN.
- ntt_done while in NTT_W/INTT_W advances in the same cycle; the counter comparison does not override it. ntt_done in any other state is ignored.
- FIN: done=1 for one cycle, then IDLE (op_ready=1 the following cycle). Back-to-back accept is therefore 1 cycle after FIN.
- wb0_en and wb1_en are never high in the same cycle except in ADD.
- ctl_step=0 in IDLE/FIN and in NTT_W/INTT_W.

Test Plan:
- Reset mid-NTT_W (reset=0 for 1 cycle) → next cycle busy=0, op_ready=1, err=0, no wb pulse.
- CT_CT_ADD with src0=3, src2=7, dst0=1, dst1=2 → 1 cycle ADD with wb0_en=wb1_en=1, ctl_src_a=3, ctl_src_b=7; done 1 cycle later; op_ready again the following cycle.
- CT_PT_MUL with ntt_done returned 1 cycle after each start → ntt_start pulses 4 times with inverse 0,1,0,1; wb0_en in cycle 7 and wb1_en in cycle 14 after accept; done at cycle 15; ctl_half flips after the first UNTWIST.
- CT_PT_MUL with NTT_TIMEOUT=8 and ntt_done never asserted → err=2'b10 after 8 wait cycles; no wb0_en/wb1_en; single done pulse.
- op_mode=11 → err=2'b01, no write enables, done pulse; a following CT_CT_ADD clears err to 0.
- op_valid held high while busy, with ntt_done pulsed in IDLE and MUL → no second accept and no state change from the stray ntt_done.
